// File: rtl/adc_scanner.sv
// rtl/adc_scanner.sv - periodic 8-channel ADC request sequencer with latest-value table
// Define ADC_SCANNER_AVG_EN to keep a running average per channel instead of the raw sample.
module adc_scanner #(
    parameter int PERIOD  = 100000,
    parameter int TIMEOUT = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  chan_mask,
    output logic [23:0] adc_in_data,
    output logic        adc_in_wr,
    input  logic [23:0] adc_out_data,
    input  logic        adc_out_wr,
    output logic [23:0] res_data,
    output logic        res_wr,
    input  logic [2:0]  rd_ch,
    output logic [9:0]  rd_val,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_tag
);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [23:0]   PER_LAST = 24'(PERIOD - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FWD, S_NEXT} state_t;

    state_t        state_q, state_d;
    logic [23:0]   per_q, per_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    mask_q, mask_d;
    logic [2:0]    ch_q, ch_d;
    logic [9:0]    val_q, val_d;
    logic [9:0]    table_q [8];
    logic [9:0]    table_d [8];
    logic [23:0]   adc_in_data_q, adc_in_data_d;
    logic          adc_in_wr_q, adc_in_wr_d;
    logic [23:0]   res_data_q, res_data_d;
    logic          res_wr_q, res_wr_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_tag_q, err_tag_d;

    logic          tick, tag_ok, tmo_hit, has_next;
    logic [2:0]    first_ch, next_ch;
    logic [9:0]    sample, new_val;
    logic          unused_bits;

    assign tick        = enable && (per_q == PER_LAST);
    assign sample      = adc_out_data[9:0];
    assign tag_ok      = (adc_out_data[23:16] == {5'b00000, ch_q});
    assign tmo_hit     = (tmo_q == TMO_LAST);
    assign unused_bits = ^adc_out_data[15:10];

    // Descending scan so the last hit is the lowest qualifying bit.
    always_comb begin
        first_ch = 3'd0;
        next_ch  = 3'd0;
        has_next = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (chan_mask[i]) first_ch = 3'(i);
            if (mask_q[i] && (3'(i) > ch_q)) begin
                next_ch  = 3'(i);
                has_next = 1'b1;
            end
        end
    end

`ifdef ADC_SCANNER_AVG_EN
    logic [7:0]  valid_q, valid_d;
    logic [11:0] avg_sum;

    always_comb begin
        avg_sum = 12'd3 * {2'b00, table_q[ch_q]} + {2'b00, sample} + 12'd2;
        new_val = valid_q[ch_q] ? avg_sum[11:2] : sample;
        valid_d = valid_q;
        if (state_q == S_WAIT && adc_out_wr && tag_ok) valid_d[ch_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= 8'h00;
        else        valid_q <= valid_d;
    end
`else
    assign new_val = sample;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            per_q         <= 24'd0;
            tmo_q         <= '0;
            mask_q        <= 8'h00;
            ch_q          <= 3'd0;
            val_q         <= 10'd0;
            for (int i = 0; i < 8; i++) table_q[i] <= 10'd0;
            adc_in_data_q <= 24'd0;
            adc_in_wr_q   <= 1'b0;
            res_data_q    <= 24'd0;
            res_wr_q      <= 1'b0;
            err_timeout_q <= 1'b0;
            err_tag_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            per_q         <= per_d;
            tmo_q         <= tmo_d;
            mask_q        <= mask_d;
            ch_q          <= ch_d;
            val_q         <= val_d;
            for (int i = 0; i < 8; i++) table_q[i] <= table_d[i];
            adc_in_data_q <= adc_in_data_d;
            adc_in_wr_q   <= adc_in_wr_d;
            res_data_q    <= res_data_d;
            res_wr_q      <= res_wr_d;
            err_timeout_q <= err_timeout_d;
            err_tag_q     <= err_tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (tick && chan_mask != 8'h00) state_d = S_REQ;
            S_REQ:   state_d = S_WAIT;
            S_WAIT: begin
                if (adc_out_wr)   state_d = tag_ok ? S_FWD : S_NEXT;
                else if (tmo_hit) state_d = S_NEXT;
            end
            S_FWD:   state_d = S_NEXT;
            S_NEXT:  state_d = (enable && has_next) ? S_REQ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        per_d         = (!enable || tick) ? 24'd0 : per_q + 24'd1;
        tmo_d         = tmo_q;
        mask_d        = mask_q;
        ch_d          = ch_q;
        val_d         = val_q;
        table_d       = table_q;
        adc_in_data_d = adc_in_data_q;
        adc_in_wr_d   = 1'b0;
        res_data_d    = res_data_q;
        res_wr_d      = 1'b0;
        err_timeout_d = err_timeout_q;
        err_tag_d     = err_tag_q;
        case (state_q)
            S_IDLE: begin
                if (tick && chan_mask != 8'h00) begin
                    mask_d = chan_mask;
                    ch_d   = first_ch;
                end
            end
            S_REQ: begin
                adc_in_data_d = {21'd0, ch_q};
                adc_in_wr_d   = 1'b1;
                tmo_d         = '0;
            end
            S_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (adc_out_wr) begin
                    if (tag_ok) begin
                        table_d[ch_q] = new_val;
                        val_d         = new_val;
                    end else begin
                        err_tag_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    err_timeout_d = 1'b1;
                end
            end
            S_FWD: begin
                res_data_d = {5'd0, ch_q, 6'd0, val_q};
                res_wr_d   = 1'b1;
            end
            S_NEXT: begin
                if (enable && has_next) ch_d = next_ch;
            end
            default: ;
        endcase
    end

    assign adc_in_data = adc_in_data_q;
    assign adc_in_wr   = adc_in_wr_q;
    assign res_data    = res_data_q;
    assign res_wr      = res_wr_q;
    assign rd_val      = table_q[rd_ch];
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_timeout_q;
    assign err_tag     = err_tag_q;
endmodule

// File: tb/tb_adc_scanner.sv
// tb/tb_adc_scanner.sv - directed bench for adc_scanner with ADC responder and result scoreboard
// Expected table values follow the running average when ADC_SCANNER_AVG_EN is defined.
module tb_adc_scanner;
`ifdef ADC_SCANNER_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  chan_mask;
    logic [23:0] adc_in_data;
    logic        adc_in_wr;
    logic [23:0] adc_out_data;
    logic        adc_out_wr;
    logic [23:0] res_data;
    logic        res_wr;
    logic [2:0]  rd_ch;
    logic [9:0]  rd_val;
    logic        busy;
    logic        err_timeout;
    logic        err_tag;

    adc_scanner #(.PERIOD(16), .TIMEOUT(512)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .chan_mask(chan_mask),
        .adc_in_data(adc_in_data), .adc_in_wr(adc_in_wr),
        .adc_out_data(adc_out_data), .adc_out_wr(adc_out_wr),
        .res_data(res_data), .res_wr(res_wr), .rd_ch(rd_ch), .rd_val(rd_val),
        .busy(busy), .err_timeout(err_timeout), .err_tag(err_tag)
    );

    typedef struct {
        logic [23:0] data;
        int          cyc;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          res_cnt = 0;
    exp_t        sb[$];
    logic [23:0] req_log[$];
    int          req_cyc[$];
    bit          rsp_silent = 1'b0;
    bit          rsp_push = 1'b1;
    int          bad_ch = -1;
    logic [9:0]  val_tab [8];
    logic [9:0]  mdl_tab [8];
    bit          mdl_valid [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] mdl_next(logic [9:0] old, bit v, logic [9:0] s);
        int a;
        a = (3 * int'(old) + int'(s) + 2) >> 2;
        if (AVG && v) return a[9:0];
        return s;
    endfunction

    // ADC model: logs every request and answers rsp_delay cycles later.
    initial begin
        bit         pend;
        bit         drove;
        int         left;
        logic [2:0] ch;
        logic [7:0] addr;
        logic [9:0] v;
        exp_t       e;
        pend = 1'b0;
        drove = 1'b0;
        left = 0;
        ch = 3'd0;
        adc_out_wr = 1'b0;
        adc_out_data = 24'd0;
        forever begin
            @(negedge clk);
            if (drove) begin
                adc_out_wr = 1'b0;
                drove = 1'b0;
            end
            if (adc_in_wr && rst_n) begin
                req_log.push_back(adc_in_data);
                req_cyc.push_back(cyc);
                if (!rsp_silent) begin
                    pend = 1'b1;
                    ch = adc_in_data[2:0];
                    left = 20;
                end
            end else if (pend) begin
                if (left > 1) begin
                    left--;
                end else begin
                    pend = 1'b0;
                    addr = (int'(ch) == bad_ch) ? 8'h03 : {5'd0, ch};
                    adc_out_data = {addr, 6'd0, val_tab[ch]};
                    adc_out_wr = 1'b1;
                    drove = 1'b1;
                    if (rd_ch == ch) chk("rd_old_on_write", rd_val, mdl_tab[ch]);
                    if (int'(ch) != bad_ch && rsp_push) begin
                        v = mdl_next(mdl_tab[ch], mdl_valid[ch], val_tab[ch]);
                        mdl_tab[ch] = v;
                        mdl_valid[ch] = 1'b1;
                        e.data = {5'd0, ch, 6'd0, v};
                        e.cyc = cyc;
                        sb.push_back(e);
                    end
                end
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && res_wr) begin
            if (sb.size() == 0) begin
                chk("res_spurious", res_wr, 0);
            end else begin
                e = sb.pop_front();
                chk("res_data", res_data, e.data);
                chk("res_latency", cyc - e.cyc, 2);
                if (rd_ch == e.data[18:16]) chk("rd_at_res", rd_val, e.data[9:0]);
            end
            res_cnt++;
        end
    end

    task automatic wait_req(int n, int budget, string tag);
        int k = 0;
        while (req_log.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(tag, req_log.size() >= n, 1);
    endtask

    task automatic wait_res(int n, int budget, string tag);
        int k = 0;
        while (res_cnt < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(tag, res_cnt >= n, 1);
    endtask

    task automatic wait_idle(int budget, string tag);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic stray(logic [7:0] addr, logic [9:0] v);
        @(negedge clk);
        adc_out_data = {addr, 6'd0, v};
        adc_out_wr = 1'b1;
        @(negedge clk);
        adc_out_wr = 1'b0;
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_adc_in_wr"}, adc_in_wr, 0);
        chk({tag, "_adc_in_data"}, adc_in_data, 0);
        chk({tag, "_res_wr"}, res_wr, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
        chk({tag, "_err_tag"}, err_tag, 0);
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i);
            #1;
            chk({tag, "_table"}, rd_val, 0);
        end
    endtask

    initial begin
        int  t0;
        int  te;
        int  k;
        bit  busy_seen;
        rst_n = 1'b0;
        enable = 1'b0;
        chan_mask = 8'h00;
        rd_ch = 3'd0;
        for (int i = 0; i < 8; i++) begin
            val_tab[i] = 10'd0;
            mdl_tab[i] = 10'd0;
            mdl_valid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Two-channel scan; mask change after the first request must not matter.
        val_tab[0] = 10'h155;
        val_tab[2] = 10'h2AA;
        rd_ch = 3'd2;
        chan_mask = 8'h05;
        enable = 1'b1;
        t0 = cyc;
        wait_req(1, 40, "t1_req0_seen");
        chk("t1_tick_to_req", req_cyc[0] - t0, 17);
        chk("t1_req0", req_log[0], 24'h000000);
        chan_mask = 8'h02;
        wait_res(2, 200, "t1_two_results");
        chk("t1_busy_at_res", busy, 1);
        @(negedge clk); #1;
        chk("t1_busy_drop", busy, 0);
        enable = 1'b0;
        chk("t1_nreq", req_log.size(), 2);
        chk("t1_req1", req_log[1], 24'h000002);
        chk("t1_rd2", rd_val, 10'h2AA);

        // Tick with an empty mask starts nothing.
        @(negedge clk);
        chan_mask = 8'h00;
        enable = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            busy_seen |= busy;
        end
        enable = 1'b0;
        chk("t_mask0_busy", busy_seen, 0);
        chk("t_mask0_nreq", req_log.size(), 2);

        // Silent ADC: timeout, advance to ch1, late answer ignored.
        rsp_silent = 1'b1;
        chan_mask = 8'h03;
        @(negedge clk);
        enable = 1'b1;
        wait_req(3, 40, "t2_req0_seen");
        k = 0;
        while (!err_timeout && k < 600) begin
            @(negedge clk); #1;
            k++;
        end
        te = cyc;
        chk("t2_timeout_latency", te - req_cyc[2], 512);
        wait_req(4, 20, "t2_req1_seen");
        chk("t2_req1", req_log[3], 24'h000001);
        enable = 1'b0;
        wait_idle(600, "t2_idle");
        stray(8'h00, 10'h3FF);
        repeat (4) @(negedge clk);
        rd_ch = 3'd0;
        #1;
        chk("t2_late_ignored", rd_val, mdl_tab[0]);
        chk("t2_no_res", res_cnt, 2);
        chk("t2_no_tag_err", err_tag, 0);

        // Wrong address for ch1: tag error, table kept, scan continues to ch2.
        rsp_silent = 1'b0;
        bad_ch = 1;
        val_tab[1] = 10'h123;
        val_tab[2] = 10'h0AB;
        chan_mask = 8'h06;
        @(negedge clk);
        enable = 1'b1;
        wait_res(3, 200, "t3_ch2_result");
        enable = 1'b0;
        wait_idle(20, "t3_idle");
        chk("t3_req_ch1", req_log[4], 24'h000001);
        chk("t3_req_ch2", req_log[5], 24'h000002);
        chk("t3_err_tag", err_tag, 1);
        rd_ch = 3'd1;
        #1;
        chk("t3_table1_kept", rd_val, 10'h000);
        bad_ch = -1;

        // Enable drops during ch0 wait: ch0 completes, nothing more requested.
        val_tab[0] = 10'h0F0;
        chan_mask = 8'hFF;
        rd_ch = 3'd0;
        @(negedge clk);
        enable = 1'b1;
        wait_req(7, 40, "t4_req0_seen");
        repeat (5) @(negedge clk);
        enable = 1'b0;
        wait_idle(100, "t4_idle");
        chk("t4_one_res", res_cnt, 4);
        chk("t4_one_req", req_log.size(), 7);
        chk("t4_rd0", rd_val, mdl_tab[0]);

        // Reset in the middle of a wait clears everything; the late answer is dropped.
        chan_mask = 8'h01;
        @(negedge clk);
        enable = 1'b1;
        wait_req(8, 40, "t5_req_seen");
        repeat (5) @(negedge clk);
        rsp_push = 1'b0;
        enable = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async_reset");
        for (int i = 0; i < 8; i++) begin
            mdl_tab[i] = 10'd0;
            mdl_valid[i] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        rd_ch = 3'd0;
        #1;
        chk("t5_stray_no_res", res_cnt, 4);
        chk("t5_stray_table", rd_val, 10'h000);
        chk("t5_stray_busy", busy, 0);
        rsp_push = 1'b1;

        // ch3 twice: raw sample or running average.
        val_tab[3] = 10'h100;
        chan_mask = 8'h08;
        rd_ch = 3'd3;
        @(negedge clk);
        enable = 1'b1;
        wait_res(5, 80, "t6_first_res");
        enable = 1'b0;
        wait_idle(20, "t6_idle1");
        chk("t6_first_value", rd_val, 10'h100);
        val_tab[3] = 10'h200;
        @(negedge clk);
        enable = 1'b1;
        wait_res(6, 80, "t6_second_res");
        enable = 1'b0;
        wait_idle(20, "t6_idle2");
        chk("t6_second_value", rd_val, AVG ? 10'h140 : 10'h200);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
